// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART receiver / host logic and the receive FIFO.
// The master drives frames and read controls; the slave reports FIFO status.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      rx_data;
  logic            rx_done;
  logic            parity_error;
  logic [1:0]      data_bit_num;
  logic            rd_en;
  logic            flush;
  logic            clr_overrun;
  logic [7:0]      rd_data;
  logic            rd_perr;
  logic            empty;
  logic            full;
  logic            almost_full;
  logic [ADDR_W:0] count;
  logic            overrun;

  modport master (
    output rx_data, rx_done, parity_error, data_bit_num, rd_en, flush, clr_overrun,
    input  rd_data, rd_perr, empty, full, almost_full, count, overrun
  );

  modport slave (
    input  rx_data, rx_done, parity_error, data_bit_num, rd_en, flush, clr_overrun,
    output rd_data, rd_perr, empty, full, almost_full, count, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures one entry per rx_done rising
// edge into a first-word-fall-through FIFO with occupancy, overrun and almost-full status.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_rx_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);

  logic [8:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              rx_done_q, rx_done_d;

  logic              push, pop, empty, full, mem_we;
  logic [7:0]        mask;
  logic [8:0]        wr_entry, rd_entry;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign push  = bus.rx_done & ~rx_done_q;
  assign pop   = bus.rd_en & ~empty;

  always_comb begin
    mask = 8'hFF;
    case (bus.data_bit_num)
      2'b00:   mask = 8'h1F;
      2'b01:   mask = 8'h3F;
      2'b10:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
  end

  assign wr_entry = {bus.parity_error, bus.rx_data & mask};

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rx_done_d = bus.rx_done;
    overrun_d = overrun_q & ~bus.clr_overrun;
    mem_we    = 1'b0;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (push && pop) begin
      // Also covers the full case: the slot being popped is the one rewritten.
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end else if (push && !full) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      count_d  = count_q + (ADDR_W+1)'(1);
    end else if (push) begin
      overrun_d = 1'b1;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d  = count_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      rx_done_q <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      rx_done_q <= rx_done_d;
    end
  end

  // Storage holds no reset; count gates everything read from it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign rd_entry        = mem_q[rd_ptr_q];
  assign bus.rd_data     = empty ? 8'h00 : rd_entry[7:0];
  assign bus.rd_perr     = empty ? 1'b0  : rd_entry[8];
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.almost_full = (count_q >= AF_C);
  assign bus.count       = count_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int AF     = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus();

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .AF_THRESH(AF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: a plain queue of {perr, data} entries.
  logic [8:0] mq[$];
  bit         m_ovr  = 1'b0;
  bit         m_prev = 1'b1;
  bit         m_push, m_pop, m_drop;
  logic [7:0] m_mask;
  int         m_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 25) $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge reset_n) begin
    mq.delete();
    m_ovr  = 1'b0;
    m_prev = 1'b1;
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_ovr  = 1'b0;
      m_prev = 1'b1;
    end else begin
      m_push = bus.rx_done && !m_prev;
      m_prev = bus.rx_done;
      m_drop = 1'b0;
      if (bus.flush) begin
        mq.delete();
      end else begin
        m_pop = bus.rd_en && (mq.size() > 0);
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          m_w    = 5 + int'(bus.data_bit_num);
          m_mask = 8'((1 << m_w) - 1);
          if (mq.size() < DEPTH) mq.push_back({bus.parity_error, bus.rx_data & m_mask});
          else m_drop = 1'b1;
        end
      end
      if (m_drop) m_ovr = 1'b1;
      else if (bus.clr_overrun) m_ovr = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_data", 32'(bus.rd_data), (mq.size() > 0) ? 32'(mq[0][7:0]) : 32'd0);
      chk("rd_perr", 32'(bus.rd_perr), (mq.size() > 0) ? 32'(mq[0][8]) : 32'd0);
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      chk("almost_full", 32'(bus.almost_full), 32'(mq.size() >= AF));
      chk("overrun", 32'(bus.overrun), 32'(m_ovr));
    end
  end

  task automatic send_frame(input logic [7:0] d, input bit p, input logic [1:0] w,
                            input bit also_pop, input bit also_flush);
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.rx_data = 8'($urandom);
    @(negedge clk);
    bus.rx_data      = d;
    bus.parity_error = p;
    bus.data_bit_num = w;
    bus.rx_done      = 1'b1;
    bus.rd_en        = also_pop;
    bus.flush        = also_flush;
    @(negedge clk);
    bus.rd_en        = 1'b0;
    bus.flush        = 1'b0;
    bus.parity_error = 1'b0;
    bus.rx_data      = 8'($urandom);
    bus.data_bit_num = 2'($urandom);
  endtask

  task automatic pop_one();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr_overrun = 1'b1;
    @(negedge clk);
    bus.clr_overrun = 1'b0;
  endtask

  int rdp[3] = '{15, 50, 85};

  initial begin
    bus.rx_data      = 8'h00;
    bus.rx_done      = 1'b1;
    bus.parity_error = 1'b0;
    bus.data_bit_num = 2'b11;
    bus.rd_en        = 1'b0;
    bus.flush        = 1'b0;
    bus.clr_overrun  = 1'b0;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // Idle-high receiver after reset must not push.
    repeat (10) @(negedge clk);
    chk("t1_empty", 32'(bus.empty), 32'd1);
    chk("t1_count", 32'(bus.count), 32'd0);
    chk("t1_rd_data", 32'(bus.rd_data), 32'd0);

    send_frame(8'hA5, 1'b0, 2'b11, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 2'b11, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 2'b11, 1'b0, 1'b0);
    chk("t2_count", 32'(bus.count), 32'd3);
    chk("t2_head0", 32'(bus.rd_data), 32'hA5);
    pop_one();
    chk("t2_head1", 32'(bus.rd_data), 32'h3C);
    pop_one();
    chk("t2_head2", 32'(bus.rd_data), 32'h81);
    chk("t2_perr2", 32'(bus.rd_perr), 32'd1);
    pop_one();
    chk("t2_empty", 32'(bus.empty), 32'd1);

    send_frame(8'hFF, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("t3_mask5", 32'(bus.rd_data), 32'h1F);
    pop_one();
    send_frame(8'hC3, 1'b0, 2'b10, 1'b0, 1'b0);
    chk("t3_mask7", 32'(bus.rd_data), 32'h43);
    pop_one();

    for (int i = 0; i < 16; i++) begin
      send_frame(8'(i), 1'b0, 2'b11, 1'b0, 1'b0);
      if (i == 10) chk("t4_af_below", 32'(bus.almost_full), 32'd0);
      if (i == 11) chk("t4_af_at12", 32'(bus.almost_full), 32'd1);
    end
    chk("t4_full", 32'(bus.full), 32'd1);
    send_frame(8'hEE, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("t4_overrun", 32'(bus.overrun), 32'd1);
    chk("t4_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("t4_order", 32'(bus.rd_data), 32'(i));
      pop_one();
    end
    pulse_clr();
    chk("t4_clr", 32'(bus.overrun), 32'd0);

    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 2'b11, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 2'b11, 1'b1, 1'b0);
    chk("t5_count", 32'(bus.count), 32'd16);
    chk("t5_overrun", 32'(bus.overrun), 32'd0);
    chk("t5_head", 32'(bus.rd_data), 32'h01);
    repeat (15) pop_one();
    chk("t5_last", 32'(bus.rd_data), 32'h77);
    pop_one();
    send_frame(8'h55, 1'b0, 2'b11, 1'b1, 1'b0);
    chk("t5_empty_push", 32'(bus.count), 32'd1);
    chk("t5_empty_data", 32'(bus.rd_data), 32'h55);
    pop_one();

    for (int i = 0; i < 16; i++) send_frame(8'(i + 8'h20), 1'b0, 2'b11, 1'b0, 1'b0);
    send_frame(8'h99, 1'b0, 2'b11, 1'b0, 1'b0);
    repeat (11) pop_one();
    chk("t6_count5", 32'(bus.count), 32'd5);
    chk("t6_ovr_set", 32'(bus.overrun), 32'd1);
    send_frame(8'h42, 1'b0, 2'b11, 1'b0, 1'b1);
    chk("t6_flush_count", 32'(bus.count), 32'd0);
    chk("t6_flush_empty", 32'(bus.empty), 32'd1);
    chk("t6_flush_ovr", 32'(bus.overrun), 32'd1);
    for (int i = 0; i < 3; i++) send_frame(8'(8'h60 + i), 1'b1, 2'b01, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(bus.count), 32'd0);
    chk("t6_rst_empty", 32'(bus.empty), 32'd1);
    chk("t6_rst_ovr", 32'(bus.overrun), 32'd0);
    chk("t6_rst_data", 32'(bus.rd_data), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        bus.rx_done      = ($urandom_range(0, 2) != 0);
        bus.rx_data      = 8'($urandom);
        bus.parity_error = 1'($urandom);
        bus.data_bit_num = 2'($urandom);
        bus.rd_en        = ($urandom_range(0, 99) < rdp[ph]);
        bus.flush        = ($urandom_range(0, 199) == 0);
        bus.clr_overrun  = ($urandom_range(0, 15) == 0);
        if (ph == 1 && c == 500) begin
          #2 reset_n = 1'b0;
          @(negedge clk);
          #2 reset_n = 1'b1;
        end
      end
    end

    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.flush = 1'b0;
    bus.clr_overrun = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
